instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch.sv | 125 ++++++++++++
 tb/tb_instruction_fetch.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC, fetches one word per instruction, waits for resolve.
// Optional FETCH_PERF_COUNTERS_EN adds cycle_count / retired_count outputs.
module instruction_fetch #(
    parameter int unsigned          PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rstn,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instruction,
    output logic [PC_WIDTH-1:0] pc,
    output logic                instr_valid,
`ifdef FETCH_PERF_COUNTERS_EN
    output logic [63:0]         cycle_count,
    output logic [63:0]         retired_count,
`endif
    input  logic                resolve_valid,
    input  logic [1:0]          next_pc_src,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                alu_result_zero
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_e                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [31:0]           instr_q, instr_d;
    logic                  taken;
    logic [PC_WIDTH-1:0]   pc_plus4;
    logic [PC_WIDTH-1:0]   next_raw;
    logic [PC_WIDTH-1:0]   next_pc;

    always_comb begin
        taken = 1'b0;
        unique case (next_pc_src)
            2'd0:    taken = 1'b0;
            2'd1:    taken = 1'b1;
            2'd2:    taken = alu_result_zero;
            default: taken = !alu_result_zero;
        endcase
        pc_plus4 = pc_q + PC_WIDTH'(4);
        next_raw = taken ? branch_target : pc_plus4;
        // Low bits cleared so JALR targets land word-aligned
        next_pc  = {next_raw[PC_WIDTH-1:2], 2'b00};
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (resolve_valid) begin
                    pc_d    = next_pc;
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign pc          = pc_q;
    assign instr_valid = (state_q == ISSUE);

`ifdef FETCH_PERF_COUNTERS_EN
    logic [63:0] cycle_q, cycle_d;
    logic [63:0] retired_q, retired_d;

    always_comb begin
        cycle_d   = cycle_q;
        retired_d = retired_q;
        if (state_q != BOOT) begin
            cycle_d = cycle_q + 64'd1;
        end
        if (state_q == ISSUE && resolve_valid) begin
            retired_d = retired_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            retired_q <= retired_d;
        end
    end

    assign cycle_count   = cycle_q;
    assign retired_count = retired_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: vector table, hand sequences, random vs. reference model.
// Counter checks are compiled in when FETCH_PERF_COUNTERS_EN is defined.
module tb_instruction_fetch;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        instr_valid;
    logic        resolve_valid = 1'b0;
    logic [1:0]  next_pc_src = '0;
    logic [31:0] branch_target = '0;
    logic        alu_result_zero = 1'b0;
`ifdef FETCH_PERF_COUNTERS_EN
    logic [63:0] cycle_count;
    logic [63:0] retired_count;
`endif

    instruction_fetch #(
        .PC_WIDTH (32),
        .RESET_PC (RPC)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .instruction     (instruction),
        .pc              (pc),
        .instr_valid     (instr_valid),
`ifdef FETCH_PERF_COUNTERS_EN
        .cycle_count     (cycle_count),
        .retired_count   (retired_count),
`endif
        .resolve_valid   (resolve_valid),
        .next_pc_src     (next_pc_src),
        .branch_target   (branch_target),
        .alu_result_zero (alu_result_zero)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;
    longint      ncyc = 0;
    longint      nret = 0;
    bit          booted = 1'b0;

    typedef struct {
        int          rw;
        int          sw;
        logic [1:0]  src;
        logic        z;
        logic [31:0] tgt;
        logic [31:0] nxt;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (booted) ncyc++;
        booted = rstn;
        @(negedge clk);
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Next PC from the architectural rules, plain arithmetic mod 2^32
    function automatic logic [31:0] ref_next(input logic [31:0] cur,
                                             input logic [1:0] src,
                                             input logic z,
                                             input logic [31:0] tgt);
        bit          take;
        longint unsigned v;
        take = (src == 2'd1) || (src == 2'd2 && z) || (src == 2'd3 && !z);
        if (take) v = 64'(tgt);
        else      v = (64'(cur) + 64'd4) % 64'h1_0000_0000;
        v = v - (v % 64'd4);
        return v[31:0];
    endfunction

    // Entered at a negedge with the DUT in FETCH for exp_pc
    task automatic do_instr(input int rw, input int sw, input logic [1:0] src,
                            input logic z, input logic [31:0] tgt,
                            input logic [31:0] nxt);
        for (int k = 0; k < rw; k++) begin
            imem_ready    = 1'b0;
            imem_rdata    = $urandom;
            resolve_valid = (k == 0);
            next_pc_src   = 2'd1;
            branch_target = $urandom;
            chk("fetch_req_wait", 64'(imem_req), 64'(1));
            chk("fetch_addr_wait", 64'(imem_addr), 64'(exp_pc));
            chk("fetch_nvalid_wait", 64'(instr_valid), 64'(0));
            step();
        end
        resolve_valid = 1'b0;
        imem_ready    = 1'b1;
        imem_rdata    = mem(exp_pc);
        chk("fetch_req", 64'(imem_req), 64'(1));
        chk("fetch_addr", 64'(imem_addr), 64'(exp_pc));
        chk("fetch_nvalid", 64'(instr_valid), 64'(0));
        step();
        for (int k = 0; k <= sw; k++) begin
            imem_ready    = 1'($urandom);
            imem_rdata    = $urandom;
            resolve_valid = (k == sw);
            if (k == sw) begin
                next_pc_src     = src;
                alu_result_zero = z;
                branch_target   = tgt;
            end else begin
                next_pc_src     = 2'($urandom);
                alu_result_zero = 1'($urandom);
                branch_target   = $urandom;
            end
            chk("issue_valid", 64'(instr_valid), 64'(1));
            chk("issue_instr", 64'(instruction), 64'(mem(exp_pc)));
            chk("issue_pc", 64'(pc), 64'(exp_pc));
            chk("issue_nreq", 64'(imem_req), 64'(0));
            step();
        end
        resolve_valid = 1'b0;
        imem_ready    = 1'b0;
        nret++;
        exp_pc = nxt;
`ifdef FETCH_PERF_COUNTERS_EN
        chk("retired_count", retired_count, 64'(nret));
        chk("cycle_count", cycle_count, 64'(ncyc));
`endif
    endtask

    task automatic chk_reset_state();
        chk("rst_req", 64'(imem_req), 64'(0));
        chk("rst_valid", 64'(instr_valid), 64'(0));
        chk("rst_pc", 64'(pc), 64'(RPC));
        chk("rst_instr", 64'(instruction), 64'h13);
`ifdef FETCH_PERF_COUNTERS_EN
        chk("rst_cycles", cycle_count, 64'(0));
        chk("rst_retired", retired_count, 64'(0));
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  rs;
        logic        rz;
        logic [31:0] rt;

        tbl[0]  = '{0, 0, 2'd0, 1'b0, 32'h0000_0000, 32'h0000_0104};
        tbl[1]  = '{0, 0, 2'd0, 1'b1, 32'h0000_0000, 32'h0000_0108};
        tbl[2]  = '{3, 0, 2'd1, 1'b0, 32'h0000_0200, 32'h0000_0200};
        tbl[3]  = '{0, 1, 2'd2, 1'b1, 32'h0000_01F0, 32'h0000_01F0};
        tbl[4]  = '{0, 0, 2'd1, 1'b0, 32'h0000_0200, 32'h0000_0200};
        tbl[5]  = '{1, 0, 2'd2, 1'b0, 32'h0000_01F0, 32'h0000_0204};
        tbl[6]  = '{0, 10, 2'd3, 1'b0, 32'h0000_0240, 32'h0000_0240};
        tbl[7]  = '{2, 0, 2'd3, 1'b1, 32'h0000_0300, 32'h0000_0244};
        tbl[8]  = '{0, 0, 2'd1, 1'b0, 32'h0000_1235, 32'h0000_1234};
        tbl[9]  = '{0, 2, 2'd1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
        tbl[10] = '{0, 0, 2'd0, 1'b0, 32'h0000_0000, 32'h0000_0000};
        tbl[11] = '{0, 0, 2'd2, 1'b1, 32'h0000_0003, 32'h0000_0000};

        #2 rstn = 1'b0;
        #1 chk_reset_state();
        step();
        step();
        // Release between edges; resolve in BOOT must be ignored
        resolve_valid = 1'b1;
        next_pc_src   = 2'd1;
        branch_target = 32'hDEAD_BEEC;
        rstn = 1'b1;
        #1 chk("boot_nreq", 64'(imem_req), 64'(0));
        step();
        resolve_valid = 1'b0;
        exp_pc = RPC;

        for (int i = 0; i < 12; i++) begin
            do_instr(tbl[i].rw, tbl[i].sw, tbl[i].src, tbl[i].z,
                     tbl[i].tgt, tbl[i].nxt);
        end

        // Asynchronous reset pulse with a request pending
        do_instr(0, 0, 2'd1, 1'b0, 32'h0000_4000, 32'h0000_4000);
        imem_ready = 1'b0;
        step();
        chk("pre_rst_req", 64'(imem_req), 64'(1));
        #2 rstn = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        #1 chk_reset_state();
        rstn = 1'b1;
        #1 chk("reboot_nreq", 64'(imem_req), 64'(0));
        imem_ready = 1'b0;
        booted = 1'b0;
        ncyc = 0;
        nret = 0;
        step();
        exp_pc = RPC;
        chk("reboot_instr", 64'(instruction), 64'h13);

        for (int i = 0; i < 40; i++) begin
            rs = 2'($urandom_range(0, 3));
            rz = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0)
                rt = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else
                rt = $urandom;
            do_instr($urandom_range(0, 3), $urandom_range(0, 3), rs, rz, rt,
                     ref_next(exp_pc, rs, rz, rt));
        end
        chk("final_addr", 64'(imem_addr), 64'(exp_pc));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
